pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Round-robin arbiter that shares one program-memory read port among several per-core instruction caches. It sits directly downstream of the icaches' miss interfaces and directly upstream of program memory. It forwards one miss at a time to memory and returns each response to the requesting cache as a one-cycle ready pulse with data.

## Interface
Parameters:
- NUM_CONSUMERS, 4: number of icache miss ports; must be ≥ 2.
- ADDR_BITS, 8: program address width.
- DATA_BITS, 16: instruction width.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-port miss request; level, held until served.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  flattened; port i occupies bits [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  per-port one-cycle response pulse.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  flattened per-port response data; each slice holds its last value.
- mem_read_valid  out  1  request to program memory; level.
- mem_read_address  out  ADDR_BITS  address presented to memory.
- mem_read_ready  in  1  memory response strobe, valid with mem_read_data.
- mem_read_data  in  DATA_BITS  memory response data.

## Operation
- The state machine has three states: IDLE, WAITING and RELAY. A register `grant` (clog2 width) records the port being served. A round-robin pointer `rr` (the same width) records where the next search starts.
- IDLE:
  - Search the ports that have consumer_read_valid set, starting at rr and wrapping modulo NUM_CONSUMERS. Take the first one found.
  - On a hit: latch grant, drive mem_read_valid <= 1, drive mem_read_address <= that port's address slice, and set rr <= (grant+1) mod NUM_CONSUMERS.
  - Then go to WAITING. With no requests, stay in IDLE.
- WAITING:
  - Hold mem_read_valid and mem_read_address stable.
  - When mem_read_ready is seen:
    - mem_read_valid <= 0.
    - Write consumer_read_data[grant] <= mem_read_data.
    - consumer_read_ready[grant] <= 1.
    - Go to RELAY.
- RELAY:
  - Lasts exactly one cycle, during which the ready pulse is visible to the consumer.
  - Clear all consumer_read_ready bits and go to IDLE.
  - This cycle exists because an icache drops its valid on the same edge on which it samples ready. Re-arbitrating during RELAY would double-serve that cache.
- The address is latched at grant. A consumer that drops valid while being served is a protocol violation, but the transaction still completes and the ready pulse is still issued.
- mem_read_ready in IDLE or RELAY is ignored, and no data slice changes.
- At most one bit of consumer_read_ready is ever high. consumer_read_data slices of ports that are not being served never change.
- Reset values:
  - State: IDLE. rr = 0, grant = 0.
  - mem_read_valid = 0, mem_read_address = 0.
  - All consumer_read_ready = 0, all consumer_read_data = 0.
- Reset mid-transaction drops the transaction. The memory shares the same reset, so no stale response is expected. Any response that does arrive afterwards is ignored under the IDLE rule.

## Timing
- Request seen in IDLE at cycle 0 → mem_read_valid high from cycle 1.
- Memory strobes mem_read_ready in cycle k (k ≥ 1) → consumer_read_ready[grant] high in cycle k+1 only. mem_read_valid is low from cycle k+1.
- The earliest next grant is decided in IDLE at cycle k+2, with mem_read_valid high again at k+3.
- Minimum throughput is one transaction per 4 cycles when memory responds in the cycle after valid rises.
- Fairness: under continuous requests from all ports, each port waits at most NUM_CONSUMERS-1 transactions.

## Test plan
- Single request: port 2 asserts valid with address 0x35 at cycle 0; memory strobes ready at cycle 3 with data 0xBEEF.
  - mem_read_valid is high in cycles 1–3 with address 0x35.
  - consumer_read_ready is 4'b0100 in cycle 4 only, and data slice 2 = 0xBEEF.
  - mem_read_valid is low in cycle 4.
- All four ports request together, with addresses 0x10/0x20/0x30/0x40 and memory latency 2 cycles.
  - Grants go in order 0, 1, 2, 3.
  - Each port receives its own data, and the other slices are unchanged.
- Fairness: port 0 re-asserts valid immediately after every response while port 3 stays requesting.
  - Grants alternate 0, 3, 0, 3.
  - Port 3 is never skipped twice.
- Reset during WAITING: assert reset for one cycle before memory responds.
  - All outputs return to 0, and rr = 0.
  - A mem_read_ready arriving afterwards produces no consumer_read_ready pulse.
- Stray strobe: pulse mem_read_ready in IDLE with data 0x1234.
  - No ready pulse is produced and no data slice changes.
- Drive icache instances on all ports with random misses and memory latencies of 1–5 cycles.
  - Every miss completes with data equal to mem[address].
  - consumer_read_ready is never multi-hot.
  - No port is granted twice for a single miss.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among several icache miss ports.
// One miss is in flight at a time; each response is returned as a one-cycle ready pulse.
module pmem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data
);

  localparam int GW = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {IDLE, WAITING, RELAY} state_t;

  state_t          state_reg;
  logic [GW-1:0]   grant_reg;
  logic [GW-1:0]   rr_reg;
  logic            hit_next;
  logic [GW-1:0]   pick_next;
  logic [GW-1:0]   rr_next;
  logic [ADDR_BITS-1:0] addr_slice [NUM_CONSUMERS];

  for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_addr_slice
    assign addr_slice[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
  end

  // Scan from the farthest offset back to rr so the nearest requester wins.
  always_comb begin : search
    int idx;
    idx       = 0;
    hit_next  = 1'b0;
    pick_next = '0;
    for (int off = NUM_CONSUMERS - 1; off >= 0; off--) begin
      idx = int'(rr_reg) + off;
      if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
      if (consumer_read_valid[idx]) begin
        hit_next  = 1'b1;
        pick_next = GW'(idx);
      end
    end
    rr_next = (pick_next == GW'(NUM_CONSUMERS - 1)) ? '0 : pick_next + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= IDLE;
      grant_reg           <= '0;
      rr_reg              <= '0;
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hit_next) begin
            grant_reg        <= pick_next;
            rr_reg           <= rr_next;
            mem_read_valid   <= 1'b1;
            mem_read_address <= addr_slice[pick_next];
            state_reg        <= WAITING;
          end
        end
        WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid                                         <= 1'b0;
            consumer_read_data[int'(grant_reg)*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[grant_reg]                         <= 1'b1;
            state_reg                                              <= RELAY;
          end
        end
        RELAY: begin
          // Hold off re-arbitration one cycle: the served cache drops valid on this edge.
          consumer_read_ready <= '0;
          state_reg           <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: single/multi request, fairness, reset, stray strobe, random misses.
module tb_pmem_arbiter;

  localparam int N  = 4;
  localparam int AB = 8;
  localparam int DB = 16;

  logic              clk;
  logic              reset;
  logic [N-1:0]      consumer_read_valid;
  logic [N*AB-1:0]   consumer_read_address;
  logic [N-1:0]      consumer_read_ready;
  logic [N*DB-1:0]   consumer_read_data;
  logic              mem_read_valid;
  logic [AB-1:0]     mem_read_address;
  logic              mem_read_ready;
  logic [DB-1:0]     mem_read_data;

  int total_cnt;
  int bad_cnt;
  int onehot_viol;
  logic [N*DB-1:0] exp_flat;

  pmem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mem_read_ready),
    .mem_read_data         (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones(consumer_read_ready) > 1) onehot_viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DB-1:0] mem_f(input logic [AB-1:0] a);
    return {a ^ 8'hC3, a} + 16'h1357;
  endfunction

  task automatic set_req(input int port, input logic [AB-1:0] a);
    consumer_read_address[port*AB +: AB] = a;
    consumer_read_valid[port] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    consumer_read_valid = '0;
    mem_read_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_flat = '0;
  endtask

  // Serve one memory transaction; entered and left at a negedge with the arbiter in IDLE.
  task automatic do_txn(input int port, input logic [AB-1:0] a, input int lat, input logic [DB-1:0] d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_read_valid && n < 20);
    check("mem_valid_rise", mem_read_valid, 1);
    check("mem_addr", mem_read_address, a);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check("mem_valid_hold", mem_read_valid, 1);
      check("mem_addr_hold", mem_read_address, a);
    end
    mem_read_ready = 1'b1;
    mem_read_data  = d;
    @(negedge clk);
    mem_read_ready = 1'b0;
    mem_read_data  = DB'($urandom);
    exp_flat[port*DB +: DB] = d;
    check("ready_pulse", consumer_read_ready, 64'(1) << port);
    check("data_slices", consumer_read_data, exp_flat);
    check("mem_valid_fall", mem_read_valid, 0);
    consumer_read_valid[port] = 1'b0;
    @(negedge clk);
    check("ready_clear", consumer_read_ready, 0);
  endtask

  initial begin
    logic [N-1:0]  pending;
    logic [AB-1:0] paddr [N];
    int            rr_m;
    int            p;

    total_cnt = 0;
    bad_cnt = 0;
    onehot_viol = 0;
    exp_flat = '0;
    reset = 1'b1;
    consumer_read_valid = '0;
    consumer_read_address = '0;
    mem_read_ready = 1'b0;
    mem_read_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_ready", consumer_read_ready, 0);
    check("rst_data", consumer_read_data, 0);
    check("rst_mem_valid", mem_read_valid, 0);
    check("rst_mem_addr", mem_read_address, 0);

    // Single request on port 2, strobe in cycle 3
    set_req(2, 8'h35);
    do_txn(2, 8'h35, 3, 16'hBEEF);
    $display("txn single port=2 addr=35 data=beef");

    // All four ports together, latency 2
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AB'((i + 1) * 16));
    for (int i = 0; i < N; i++) begin
      do_txn(i, AB'((i + 1) * 16), 2, DB'(16'hA000 + i));
      $display("txn all4 port=%0d", i);
    end

    // Fairness: port 0 re-requests immediately, port 3 stays requesting
    set_req(0, 8'h05);
    set_req(3, 8'h0C);
    for (int i = 0; i < 4; i++) begin
      p = (i % 2 == 0) ? 0 : 3;
      do_txn(p, (p == 0) ? 8'h05 : 8'h0C, 1, DB'(16'hF000 + i));
      set_req(p, (p == 0) ? 8'h05 : 8'h0C);
      $display("txn fair port=%0d", p);
    end
    consumer_read_valid = '0;

    // Reset during WAITING; rr moved off zero first
    do_reset();
    set_req(1, 8'h11);
    do_txn(1, 8'h11, 1, 16'h1111);
    set_req(0, 8'h22);
    set_req(3, 8'h33);
    @(negedge clk);
    check("pre_reset_grant_addr", mem_read_address, 8'h33);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    consumer_read_valid = '0;
    exp_flat = '0;
    check("midrst_mem_valid", mem_read_valid, 0);
    check("midrst_mem_addr", mem_read_address, 0);
    check("midrst_ready", consumer_read_ready, 0);
    check("midrst_data", consumer_read_data, 0);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    @(negedge clk);
    mem_read_ready = 1'b0;
    check("late_strobe_ready", consumer_read_ready, 0);
    check("late_strobe_data", consumer_read_data, 0);
    @(negedge clk);
    check("late_strobe_ready2", consumer_read_ready, 0);
    set_req(0, 8'h22);
    set_req(3, 8'h33);
    do_txn(0, 8'h22, 2, 16'h2222);
    do_txn(3, 8'h33, 2, 16'h3333);
    $display("txn after_reset ports=0,3");

    // Stray strobe in IDLE
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h1234;
    @(negedge clk);
    mem_read_ready = 1'b0;
    check("stray_ready", consumer_read_ready, 0);
    check("stray_data", consumer_read_data, exp_flat);
    check("stray_mem_valid", mem_read_valid, 0);
    @(negedge clk);
    check("stray_ready2", consumer_read_ready, 0);
    $display("txn stray strobe");

    // Random misses against a round-robin reference
    do_reset();
    rr_m = 0;
    pending = '0;
    for (int t = 0; t < 40; t++) begin
      if (pending == '0) begin
        p = $urandom_range(0, N - 1);
        pending[p] = 1'b1;
        paddr[p] = AB'($urandom_range(0, 255));
        set_req(p, paddr[p]);
      end
      p = -1;
      for (int off = 0; off < N; off++) begin
        if (p < 0 && pending[(rr_m + off) % N]) p = (rr_m + off) % N;
      end
      do_txn(p, paddr[p], $urandom_range(1, 5), mem_f(paddr[p]));
      $display("txn rand %0d port=%0d addr=%h", t, p, paddr[p]);
      pending[p] = 1'b0;
      rr_m = (p + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1'b1;
          paddr[i] = AB'($urandom_range(0, 255));
          set_req(i, paddr[i]);
        end
      end
    end

    check("ready_onehot", onehot_viol, 0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
